uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side control unit for the UART serial peripheral. It synchronizes the raw serial line, detects start bits, times and samples each bit at mid-period, and assembles the data bits. It checks the stop bit and delivers each completed byte to the 8-bit receive data buffer with a single-cycle load strobe. It sits between the pad-side `serial_in` and the receive data buffer, and is the only source of that buffer's load command.

## Interface
- `CLKS_PER_BIT`, default 10: clock cycles per serial bit period; legal range is 4 to 65535.
- `DATA_BITS`, default 8: data bits per frame; fixed at 8 for this release, and elaboration fails for any other value.
- `clk`  in  1  system clock
- `n_rst`  in  1  reset, asynchronous, active-low
- `serial_in`  in  1  raw, unsynchronized serial line; idle level is 1
- `packet_data`  out  8  assembled byte, LSB received first
- `load_buffer`  out  1  one-cycle strobe: `packet_data` is valid, load it into the buffer
- `framing_error`  out  1  the last frame's stop bit was sampled low
- `rx_busy`  out  1  high in every state except IDLE

## Operation
- **Synchronizer:** a 2-flop synchronizer followed by a third flop for edge detection. All three flops reset to 1.
- **Sample counter:** counts down from a loaded value. Width is `$clog2(CLKS_PER_BIT)`.
- **Bit index:** counts 0..7.
- **Shift register:** shifts right, with the new bit entering at MSB.

FSM states and transitions:
- **IDLE:** on a falling edge of the synchronized line (previous 1, current 0), go to START. Load the counter with `CLKS_PER_BIT/2 - 1` (floor division) and clear `framing_error`.
- **START:** when the counter reaches 0, sample the line.
  - Sample is 0: go to DATA and load the counter with `CLKS_PER_BIT - 1`.
  - Sample is 1: treat as a glitch and return to IDLE. Do not pulse `load_buffer` and do not set `framing_error`.
- **DATA:** at each counter expiry, shift the sampled bit in and reload the counter. After bit index 7, go to STOP.
- **STOP:** when the counter expires, sample the stop bit.
  - Sample is 1: go to LOAD.
  - Sample is 0: set `framing_error` and go to WAIT_IDLE.
- **LOAD:** assert `load_buffer` for exactly one cycle, drive the shift register onto `packet_data`, then go to IDLE.
- **WAIT_IDLE:** stay until the synchronized line reads 1, then go to IDLE. This prevents a held-low line from being mistaken for repeated start bits.

Output behaviour:
- `packet_data` updates only in LOAD and holds its value otherwise. A frame with a framing error never updates it.
- `framing_error` is sticky. It clears only at the next start-bit detection.
- Reset values: state IDLE; `packet_data` = 8'hFF; `load_buffer` = 0; `framing_error` = 0; `rx_busy` = 0; counter, bit index and shift register all 0.
- Reset asserted mid-frame aborts the frame immediately: no load and no error. The next frame requires a fresh 1→0 edge after reset is released.

## Timing
- **Synchronizer delay:** `serial_in` falling before clock edge E is first seen as the synchronized 0 at edge E+1. Call the edge at which the FSM enters START T0 = E+2.
- **Start-bit sample:** at T0 + `CLKS_PER_BIT/2`.
- **Data bit i (i = 0..7):** sampled at T0 + `CLKS_PER_BIT/2` + (i+1)·`CLKS_PER_BIT`.
- **Stop-bit sample:** at T0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`. With the defaults this is T0+95.
- **Load strobe:** `load_buffer` is high during the cycle after the stop-bit sample (T0+96 with defaults), together with the new `packet_data`.
- **Back-to-back frames:** IDLE is re-entered the cycle after LOAD. A start edge arriving immediately after a 1-bit stop is detected without loss.
- `load_buffer` is never high for two consecutive cycles.
- **Overrun:** handled by the receive buffer. This block never stalls and never waits for the buffer to be read.

## Structure
- The `uart_pkg` shared package holds:
  - `rx_state_t` enum (IDLE, START, DATA, STOP, LOAD, WAIT_IDLE)
  - `UART_IDLE_LVL` = 1'b1
  - `UART_DATA_BITS` = 8
- One sub-module, `rx_bit_timer`. It is a loadable down-counter with inputs `load`, `load_val`, `en` and a one-cycle `expire` output, and is parameterized by `CLKS_PER_BIT`. The FSM, synchronizer and shift register stay in the top module.

## Test plan
- **Reset:** assert `n_rst` low with `serial_in`=1 → `packet_data`=8'hFF, `load_buffer`=0, `framing_error`=0, `rx_busy`=0.
- **Nominal frame:** 0xA5 sent at 10 clk/bit with stop=1 → one `load_buffer` pulse at T0+96, `packet_data`=8'hA5, `framing_error`=0.
- **Framing error:** 0x3C sent with stop=0 and the line then held low for 30 cycles → no `load_buffer` pulse, `framing_error`=1, `packet_data` unchanged, FSM stays in WAIT_IDLE until the line rises. The next valid frame 0x01 clears the error and loads 8'h01.
- **Glitch rejection:** `serial_in` low for 3 cycles, then high → FSM returns to IDLE at T0+5, no load, no error, `rx_busy` falls.
- **Back-to-back frames:** 0xFF followed by 0x00 with 1-bit stops and no idle gap → two `load_buffer` pulses exactly 100 cycles apart, with data 8'hFF then 8'h00.
- **Reset mid-frame:** assert `n_rst` at data bit 4 of 0x55 → outputs return to reset values, with no load pulse after release until a new full frame arrives.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t     : receive FSM state encoding
//   UART_IDLE_LVL  : level of an idle serial line
//   UART_DATA_BITS : data bits per frame
package uart_pkg;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam int   UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    LOAD      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive-side signal bundle between the pad, the receive controller and
// the receive data buffer.
//   serial_in     : raw serial line, idle high
//   packet_data   : assembled byte, LSB received first
//   load_buffer   : one-cycle strobe, packet_data is valid
//   framing_error : last frame's stop bit was sampled low (sticky)
//   rx_busy       : receiver is not idle
// master = receive controller, slave = pad/buffer side.
interface uart_rx_ctrl_if import uart_pkg::*; ();

  logic                      serial_in;
  logic [UART_DATA_BITS-1:0] packet_data;
  logic                      load_buffer;
  logic                      framing_error;
  logic                      rx_busy;

  modport master (
    input  serial_in,
    output packet_data, load_buffer, framing_error, rx_busy
  );

  modport slave (
    output serial_in,
    input  packet_data, load_buffer, framing_error, rx_busy
  );

endinterface

// File: rtl/rx_bit_timer.sv
// Loadable down-counter used to time bit sampling points.
//   clk, n_rst : clock, async active-low reset
//   load       : load counter with load_val (takes priority over en)
//   load_val   : reload value
//   en         : count down while high; holds at zero
//   expire     : high for the cycle in which an enabled count sits at zero
module rx_bit_timer #(
  parameter  int CLKS_PER_BIT = 10,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (en && (count_q != '0))
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  // The controller reloads or leaves the timed state on expiry, so this
  // never stays high for more than one cycle in normal operation.
  assign expire = en && (count_q == '0);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronizes the serial line, detects start
// bits, samples each bit at mid-period, assembles the byte, checks the
// stop bit and strobes the completed byte into the receive buffer.
//   clk, n_rst : clock, async active-low reset
//   rx_if      : serial_in in; packet_data, load_buffer, framing_error,
//                rx_busy out
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a 1->0 edge
// START     | timing to the middle of the start bit, rejecting glitches
// DATA      | sampling 8 data bits, one per bit period
// STOP      | timing to the middle of the stop bit
// LOAD      | presenting the byte to the buffer (load strobe next cycle)
// WAIT_IDLE | framing error seen, waiting for the line to return high
module uart_rx_ctrl import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic           clk,
  input  logic           n_rst,
  uart_rx_ctrl_if.master rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

  if (DATA_BITS != UART_DATA_BITS) begin : g_bad_data_bits
    $error("uart_rx_ctrl: DATA_BITS must be 8");
  end
  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("uart_rx_ctrl: CLKS_PER_BIT must be 4..65535");
  end

  logic                      sync1_q, sync2_q, sync3_q;
  rx_state_t                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] packet_data_q, packet_data_d;
  logic                      load_buffer_q, load_buffer_d;
  logic                      framing_error_q, framing_error_d;
  logic                      rx_busy_q, rx_busy_d;

  logic             line;
  logic             fall;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_en;
  logic             tmr_expire;

  assign line = sync2_q;
  assign fall = sync3_q && !sync2_q;

  rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    bit_idx_d       = bit_idx_q;
    packet_data_d   = packet_data_q;
    framing_error_d = framing_error_q;
    load_buffer_d   = 1'b0;
    tmr_load        = 1'b0;
    tmr_load_val    = FULL_LOAD;
    tmr_en          = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d         = START;
          tmr_load        = 1'b1;
          tmr_load_val    = HALF_LOAD;
          framing_error_d = 1'b0;
          bit_idx_d       = '0;
        end
      end
      START: begin
        if (tmr_expire) begin
          // A line back at idle by mid start bit was a glitch.
          if (line == UART_IDLE_LVL) begin
            state_d = IDLE;
          end else begin
            state_d  = DATA;
            tmr_load = 1'b1;
          end
        end
      end
      DATA: begin
        if (tmr_expire) begin
          shift_d  = {line, shift_q[UART_DATA_BITS-1:1]};
          tmr_load = 1'b1;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tmr_expire) begin
          if (line == UART_IDLE_LVL) begin
            state_d = LOAD;
          end else begin
            framing_error_d = 1'b1;
            state_d         = WAIT_IDLE;
          end
        end
      end
      LOAD: begin
        load_buffer_d = 1'b1;
        packet_data_d = shift_q;
        state_d       = IDLE;
      end
      WAIT_IDLE: begin
        if (line == UART_IDLE_LVL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rx_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      sync3_q         <= 1'b1;
      state_q         <= IDLE;
      shift_q         <= '0;
      bit_idx_q       <= '0;
      packet_data_q   <= '1;
      load_buffer_q   <= 1'b0;
      framing_error_q <= 1'b0;
      rx_busy_q       <= 1'b0;
    end else begin
      sync1_q         <= rx_if.serial_in;
      sync2_q         <= sync1_q;
      sync3_q         <= sync2_q;
      state_q         <= state_d;
      shift_q         <= shift_d;
      bit_idx_q       <= bit_idx_d;
      packet_data_q   <= packet_data_d;
      load_buffer_q   <= load_buffer_d;
      framing_error_q <= framing_error_d;
      rx_busy_q       <= rx_busy_d;
    end
  end

  assign rx_if.packet_data   = packet_data_q;
  assign rx_if.load_buffer   = load_buffer_q;
  assign rx_if.framing_error = framing_error_q;
  assign rx_if.rx_busy       = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl at 10 clocks per bit.
module tb_uart_rx_ctrl;

  localparam int CPB = 10;

  logic clk;
  logic n_rst;
  int   cyc;
  int   pass_cnt;
  int   total_cnt;

  int          pulse_cyc[$];
  logic [7:0]  pulse_data[$];
  logic        prev_load;
  logic        double_pulse;

  uart_rx_ctrl_if rx_if ();

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .rx_if (rx_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  // Record every load strobe with the cycle number of the edge that raised it.
  initial begin
    prev_load    = 1'b0;
    double_pulse = 1'b0;
  end
  always @(negedge clk) begin
    if (rx_if.load_buffer === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_data.push_back(rx_if.packet_data);
      if (prev_load) double_pulse = 1'b1;
    end
    prev_load = (rx_if.load_buffer === 1'b1);
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_if.serial_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic clear_pulses();
    pulse_cyc.delete();
    pulse_data.delete();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    rx_if.serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (rx_if.packet_data !== 8'hFF) $display("FAIL reset_data: got %h expected ff", rx_if.packet_data);
    else pass_cnt++;
    total_cnt++;
    if (rx_if.load_buffer !== 1'b0) $display("FAIL reset_load: got %b expected 0", rx_if.load_buffer);
    else pass_cnt++;
    total_cnt++;
    if (rx_if.framing_error !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", rx_if.framing_error);
    else pass_cnt++;
    total_cnt++;
    if (rx_if.rx_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", rx_if.rx_busy);
    else pass_cnt++;
    n_rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    int n;
    clear_pulses();
    align();
    n = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    total_cnt++;
    if (pulse_cyc.size() !== 1) $display("FAIL nominal_pulses: got %0d expected 1", pulse_cyc.size());
    else pass_cnt++;
    total_cnt++;
    if (pulse_cyc[0] !== n + 99) $display("FAIL nominal_time: got %0d expected %0d", pulse_cyc[0], n + 99);
    else pass_cnt++;
    total_cnt++;
    if (pulse_data[0] !== 8'hA5) $display("FAIL nominal_data: got %h expected a5", pulse_data[0]);
    else pass_cnt++;
    total_cnt++;
    if (rx_if.framing_error !== 1'b0) $display("FAIL nominal_ferr: got %b expected 0", rx_if.framing_error);
    else pass_cnt++;
    total_cnt++;
    if (rx_if.rx_busy !== 1'b0) $display("FAIL nominal_busy: got %b expected 0", rx_if.rx_busy);
    else pass_cnt++;
  endtask

  task automatic test_framing_error();
    int n;
    clear_pulses();
    align();
    send_frame(8'h3C, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    total_cnt++;
    if (pulse_cyc.size() !== 0) $display("FAIL ferr_no_load: got %0d expected 0", pulse_cyc.size());
    else pass_cnt++;
    total_cnt++;
    if (rx_if.framing_error !== 1'b1) $display("FAIL ferr_set: got %b expected 1", rx_if.framing_error);
    else pass_cnt++;
    total_cnt++;
    if (rx_if.packet_data !== 8'hA5) $display("FAIL ferr_data_held: got %h expected a5", rx_if.packet_data);
    else pass_cnt++;
    total_cnt++;
    if (rx_if.rx_busy !== 1'b1) $display("FAIL ferr_wait_idle_busy: got %b expected 1", rx_if.rx_busy);
    else pass_cnt++;
    rx_if.serial_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total_cnt++;
    if (rx_if.rx_busy !== 1'b0) $display("FAIL ferr_back_idle: got %b expected 0", rx_if.rx_busy);
    else pass_cnt++;
    total_cnt++;
    if (rx_if.framing_error !== 1'b1) $display("FAIL ferr_sticky: got %b expected 1", rx_if.framing_error);
    else pass_cnt++;
    n = cyc;
    send_frame(8'h01, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    total_cnt++;
    if (pulse_cyc.size() !== 1) $display("FAIL ferr_next_pulses: got %0d expected 1", pulse_cyc.size());
    else pass_cnt++;
    total_cnt++;
    if (pulse_data[0] !== 8'h01) $display("FAIL ferr_next_data: got %h expected 01", pulse_data[0]);
    else pass_cnt++;
    total_cnt++;
    if (pulse_cyc[0] !== n + 99) $display("FAIL ferr_next_time: got %0d expected %0d", pulse_cyc[0], n + 99);
    else pass_cnt++;
    total_cnt++;
    if (rx_if.framing_error !== 1'b0) $display("FAIL ferr_cleared: got %b expected 0", rx_if.framing_error);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    clear_pulses();
    align();
    rx_if.serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_if.serial_in = 1'b1;
    // Start-bit sample falls 8 edges after the drive edge; 3 already passed.
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (rx_if.rx_busy !== 1'b1) $display("FAIL glitch_busy_before: got %b expected 1", rx_if.rx_busy);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (rx_if.rx_busy !== 1'b0) $display("FAIL glitch_idle_at_t0p5: got %b expected 0", rx_if.rx_busy);
    else pass_cnt++;
    repeat (20) @(posedge clk);
    #1;
    total_cnt++;
    if (pulse_cyc.size() !== 0) $display("FAIL glitch_no_load: got %0d expected 0", pulse_cyc.size());
    else pass_cnt++;
    total_cnt++;
    if (rx_if.framing_error !== 1'b0) $display("FAIL glitch_no_ferr: got %b expected 0", rx_if.framing_error);
    else pass_cnt++;
    total_cnt++;
    if (rx_if.packet_data !== 8'h01) $display("FAIL glitch_data_held: got %h expected 01", rx_if.packet_data);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int n;
    clear_pulses();
    double_pulse = 1'b0;
    align();
    n = cyc;
    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    total_cnt++;
    if (pulse_cyc.size() !== 2) $display("FAIL b2b_pulses: got %0d expected 2", pulse_cyc.size());
    else pass_cnt++;
    total_cnt++;
    if (pulse_cyc[0] !== n + 99) $display("FAIL b2b_time0: got %0d expected %0d", pulse_cyc[0], n + 99);
    else pass_cnt++;
    total_cnt++;
    if (pulse_cyc[1] - pulse_cyc[0] !== 100) $display("FAIL b2b_spacing: got %0d expected 100", pulse_cyc[1] - pulse_cyc[0]);
    else pass_cnt++;
    total_cnt++;
    if (pulse_data[0] !== 8'hFF) $display("FAIL b2b_data0: got %h expected ff", pulse_data[0]);
    else pass_cnt++;
    total_cnt++;
    if (pulse_data[1] !== 8'h00) $display("FAIL b2b_data1: got %h expected 00", pulse_data[1]);
    else pass_cnt++;
    total_cnt++;
    if (double_pulse !== 1'b0) $display("FAIL b2b_single_cycle_strobe: got %b expected 0", double_pulse);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int n;
    d = 8'h55;
    clear_pulses();
    align();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx_if.serial_in = d[4];
    repeat (5) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    total_cnt++;
    if (rx_if.packet_data !== 8'hFF) $display("FAIL rstmid_data: got %h expected ff", rx_if.packet_data);
    else pass_cnt++;
    total_cnt++;
    if (rx_if.rx_busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", rx_if.rx_busy);
    else pass_cnt++;
    total_cnt++;
    if (rx_if.framing_error !== 1'b0) $display("FAIL rstmid_ferr: got %b expected 0", rx_if.framing_error);
    else pass_cnt++;
    rx_if.serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    total_cnt++;
    if (pulse_cyc.size() !== 0) $display("FAIL rstmid_no_load: got %0d expected 0", pulse_cyc.size());
    else pass_cnt++;
    n = cyc;
    send_frame(8'h55, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    total_cnt++;
    if (pulse_cyc.size() !== 1) $display("FAIL rstmid_new_pulses: got %0d expected 1", pulse_cyc.size());
    else pass_cnt++;
    total_cnt++;
    if (pulse_data[0] !== 8'h55) $display("FAIL rstmid_new_data: got %h expected 55", pulse_data[0]);
    else pass_cnt++;
    total_cnt++;
    if (pulse_cyc[0] !== n + 99) $display("FAIL rstmid_new_time: got %0d expected %0d", pulse_cyc[0], n + 99);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    n_rst = 1'b0;
    rx_if.serial_in = 1'b1;
    test_reset();
    test_nominal();
    test_framing_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
